// File: rtl/delay_align_ctrl.sv
// Programmable cycle delay line with safe reconfiguration (flush/refill).
// Optional monitor counters: define DELAY_ALIGN_CTRL_MON_EN.
module delay_align_ctrl #(
  parameter int MAX_DELAY     = 16,
  parameter int D_WIDTH       = 32,
  parameter int DLY_W         = 5,
  parameter int DEFAULT_DELAY = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [DLY_W-1:0]   cfg_delay,
  input  logic               cfg_load,
  output logic               cfg_ready,
  output logic               cfg_err,
  output logic [DLY_W-1:0]   cur_delay,
  output logic               busy,
  input  logic [D_WIDTH-1:0] data_in,
  input  logic               data_in_valid,
  output logic [D_WIDTH-1:0] data_out,
  output logic               data_out_valid
`ifdef DELAY_ALIGN_CTRL_MON_EN
  ,
  output logic [15:0]        mon_reconfig_cnt,
  output logic [15:0]        mon_err_cnt
`endif
);

  localparam logic [0:0] ST_RUN   = 1'b0;
  localparam logic [0:0] ST_FLUSH = 1'b1;

  localparam int AW = (MAX_DELAY > 1) ? $clog2(MAX_DELAY) : 1;
  localparam logic [DLY_W:0]   MAX_X  = (DLY_W+1)'(MAX_DELAY);
  localparam logic [DLY_W-1:0] MAX_N  = DLY_W'(MAX_DELAY);
  localparam logic [DLY_W-1:0] DEF_N  = DLY_W'(DEFAULT_DELAY);
  localparam logic [AW-1:0]    WP_TOP = AW'(MAX_DELAY - 1);

  logic [0:0]         state_q, state_d;
  logic [DLY_W-1:0]   count_q, count_d;
  logic [DLY_W-1:0]   cur_q, cur_d;
  logic               err_q, err_d;
  logic [AW-1:0]      wp_q, wp_d;
  logic [AW-1:0]      rd_idx;
  logic [DLY_W:0]     wp_x;
  logic [DLY_W:0]     rd_sum;
  logic [DLY_W-AW:0]  unused_rd;
  logic [MAX_DELAY-1:0] vld_q, vld_d;
  logic [D_WIDTH-1:0] mem_q [MAX_DELAY];
  logic [D_WIDTH-1:0] dout_q, dout_d;
  logic               vout_q, vout_d;
  logic               in_range;
  logic               accept;
  logic               reject;

  assign in_range = (cfg_delay != '0) && (cfg_delay <= MAX_N);
  assign accept   = (state_q == ST_RUN) && cfg_load && in_range;
  assign reject   = (state_q == ST_RUN) && cfg_load && !in_range;

  // Read slot is the one written cur_delay edges ago, read before overwrite.
  always_comb begin
    wp_x   = {{(DLY_W+1-AW){1'b0}}, wp_q};
    rd_sum = wp_x + MAX_X - {1'b0, cur_q};
    if (rd_sum >= MAX_X) begin
      rd_sum = rd_sum - MAX_X;
    end
    rd_idx    = rd_sum[AW-1:0];
    unused_rd = rd_sum[DLY_W:AW];
  end

  always_comb begin
    wp_d = (wp_q == WP_TOP) ? '0 : wp_q + 1'b1;
  end

  always_comb begin
    vld_d         = accept ? '0 : vld_q;
    vld_d[wp_q]   = data_in_valid;
    vout_d        = accept ? 1'b0 : vld_q[rd_idx];
    dout_d        = vout_d ? mem_q[rd_idx] : '0;
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    cur_d   = cur_q;
    err_d   = reject;
    unique case (state_q)
      ST_RUN: begin
        if (accept) begin
          cur_d   = cfg_delay;
          count_d = cfg_delay;
          state_d = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        count_d = count_q - 1'b1;
        if (count_q <= 1) begin
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_FLUSH;
      count_q <= DEF_N;
      cur_q   <= DEF_N;
      err_q   <= 1'b0;
      wp_q    <= '0;
      vld_q   <= '0;
      vout_q  <= 1'b0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      cur_q   <= cur_d;
      err_q   <= err_d;
      wp_q    <= wp_d;
      vld_q   <= vld_d;
      vout_q  <= vout_d;
      dout_q  <= dout_d;
    end
  end

  // Payload storage needs no reset; the valid bits gate it.
  always_ff @(posedge clk) begin
    mem_q[wp_q] <= data_in;
  end

  assign cfg_ready      = (state_q == ST_RUN);
  assign busy           = (state_q == ST_FLUSH);
  assign cfg_err        = err_q;
  assign cur_delay      = cur_q;
  assign data_out       = dout_q;
  assign data_out_valid = vout_q;

`ifdef DELAY_ALIGN_CTRL_MON_EN
  logic [15:0] rcfg_q, rcfg_d;
  logic [15:0] errc_q, errc_d;

  always_comb begin
    rcfg_d = rcfg_q;
    errc_d = errc_q;
    if (accept && (rcfg_q != 16'hFFFF)) begin
      rcfg_d = rcfg_q + 16'd1;
    end
    if (reject && (errc_q != 16'hFFFF)) begin
      errc_d = errc_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rcfg_q <= '0;
      errc_q <= '0;
    end else begin
      rcfg_q <= rcfg_d;
      errc_q <= errc_d;
    end
  end

  assign mon_reconfig_cnt = rcfg_q;
  assign mon_err_cnt      = errc_q;
`endif

endmodule

// File: tb/tb_delay_align_ctrl.sv
// Scoreboard bench for delay_align_ctrl against an edge-indexed history model.
// Monitor counters are checked when DELAY_ALIGN_CTRL_MON_EN is defined.
module tb_delay_align_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [4:0]  cfg_delay = '0;
  logic        cfg_load = 1'b0;
  logic        cfg_ready;
  logic        cfg_err;
  logic [4:0]  cur_delay;
  logic        busy;
  logic [31:0] data_in = '0;
  logic        data_in_valid = 1'b0;
  logic [31:0] data_out;
  logic        data_out_valid;
`ifdef DELAY_ALIGN_CTRL_MON_EN
  logic [15:0] mon_reconfig_cnt;
  logic [15:0] mon_err_cnt;
`endif

  delay_align_ctrl #(
    .MAX_DELAY(16), .D_WIDTH(32), .DLY_W(5), .DEFAULT_DELAY(8)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_delay(cfg_delay), .cfg_load(cfg_load),
    .cfg_ready(cfg_ready), .cfg_err(cfg_err),
    .cur_delay(cur_delay), .busy(busy),
    .data_in(data_in), .data_in_valid(data_in_valid),
    .data_out(data_out), .data_out_valid(data_out_valid)
`ifdef DELAY_ALIGN_CTRL_MON_EN
    ,
    .mon_reconfig_cnt(mon_reconfig_cnt),
    .mon_err_cnt(mon_err_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        v;
    logic [31:0] d;
    logic        busy;
    logic        rdy;
    logic        err;
    logic [4:0]  cd;
    logic [15:0] nacc;
    logic [15:0] nrej;
  } exp_t;

  exp_t q[$];
  int n_chk = 0;
  int n_fail = 0;

  // Reference model: remembers every input pair by edge number.
  logic [31:0] hd [int];
  bit          hv [int];
  int t = 0;
  int clr = 0;
  int dly = 8;
  int flush_left = 8;
  int nacc = 0;
  int nrej = 0;

  always @(posedge clk) begin
    exp_t e;
    int s;
    bit cleared;
    e = '0;
    cleared = 0;
    if (!rst_n) begin
      dly = 8;
      clr = t + 1;
      flush_left = 8;
      nacc = 0;
      nrej = 0;
    end else begin
      if (flush_left == 0 && cfg_load) begin
        if (cfg_delay >= 1 && cfg_delay <= 16) begin
          dly = cfg_delay;
          clr = t;
          flush_left = dly;
          cleared = 1;
          if (nacc < 65535) nacc++;
        end else begin
          e.err = 1'b1;
          if (nrej < 65535) nrej++;
        end
      end else if (flush_left > 0) begin
        flush_left--;
      end
      hd[t] = data_in;
      hv[t] = data_in_valid;
      s = t - dly;
      if (!cleared && s >= clr && hv[s]) begin
        e.v = 1'b1;
        e.d = hd[s];
      end
    end
    e.busy = (flush_left > 0);
    e.rdy  = (flush_left == 0);
    e.cd   = 5'(dly);
    e.nacc = 16'(nacc);
    e.nrej = 16'(nrej);
    q.push_back(e);
    t++;
  end

  always @(negedge clk) begin
    exp_t e;
    exp_t g;
    if (q.size() > 0) begin
      e = q.pop_front();
      g = '0;
      g.v = data_out_valid;
      g.d = data_out;
      g.busy = busy;
      g.rdy = cfg_ready;
      g.err = cfg_err;
      g.cd = cur_delay;
`ifdef DELAY_ALIGN_CTRL_MON_EN
      g.nacc = mon_reconfig_cnt;
      g.nrej = mon_err_cnt;
`else
      g.nacc = e.nacc;
      g.nrej = e.nrej;
`endif
      n_chk++;
      if (g !== e) begin
        n_fail++;
        $display("FAIL outputs t=%0t got v=%b d=%h busy=%b rdy=%b err=%b cd=%0d acc=%0d rej=%0d required v=%b d=%h busy=%b rdy=%b err=%b cd=%0d acc=%0d rej=%0d",
          $time, g.v, g.d, g.busy, g.rdy, g.err, g.cd, g.nacc, g.nrej,
          e.v, e.d, e.busy, e.rdy, e.err, e.cd, e.nacc, e.nrej);
      end
    end
  end

  task automatic cyc(input bit ld, input int cd, input bit v, input int d);
    @(negedge clk);
    #2;
    cfg_load = ld;
    cfg_delay = 5'(cd);
    data_in_valid = v;
    data_in = 32'(d);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    for (int i = 0; i < 20; i++) cyc(0, 0, 1, i);
    for (int i = 0; i < 12; i++) cyc(i == 2, 3, 1, 'hA0 + i);
    cyc(1, 0, 1, 'hB0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 1, 'hB1 + i);
    cyc(1, 17, 1, 'hB4);
    for (int i = 0; i < 3; i++) cyc(0, 0, 1, 'hB5 + i);
    cyc(1, 16, 1, 'hC000);
    for (int i = 1; i < 64; i++) begin
      cyc(0, 0, (i % 4 == 0) || (i % 4 == 3), 'hC000 + i);
    end
    cyc(1, 5, 1, 'hD0);
    cyc(1, 12, 1, 'hD1);
    for (int i = 0; i < 8; i++) cyc(0, 0, 1, 'hD2 + i);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_chk++;
    if (data_out_valid !== 1'b0 || data_out !== '0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL async_reset got v=%b d=%h busy=%b required v=0 d=0 busy=1",
        data_out_valid, data_out, busy);
    end
    @(negedge clk);
    #2 rst_n = 1'b1;
    for (int i = 0; i < 20; i++) cyc(0, 0, 1, 'hE0 + i);
    for (int i = 0; i < 600; i++) begin
      cyc($urandom_range(0, 7) == 0, $urandom_range(0, 20),
          $urandom_range(0, 2) != 0, $urandom);
    end
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
